// File: rtl/branch_direction_predictor.sv
// ---------------------------------------------------------------------------
// branch_direction_predictor
//
// Gshare direction predictor for the fetch stage. It sits beside the BTB and
// lines up with the BTB's registered output. A fetch PC is hashed with the
// global history to select a 2-bit saturating counter. One cycle later, that
// counter is combined with the target the BTB returns. The result is the
// taken decision and the next fetch PC.
//
// Execute trains the table with resolved conditional branches. The global
// history is also shifted at commit time, so it is never speculative. A
// saturating count of reported mispredictions is kept as well.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   arst_n           asynchronous active-low reset
//   en               lookup enable (0 = fetch stall, lookup registers hold)
//   current_pc       fetch PC presented for lookup
//   btb_target       BTB target, one cycle after current_pc (0 = BTB miss)
//   upd_valid        resolved conditional branch from execute
//   upd_pc           PC of the resolved branch
//   upd_ghr          history that was used when that branch was predicted
//   upd_taken        actual branch outcome
//   upd_mispredict   execute flagged a misprediction (qualified by upd_valid)
//   pred_taken       counter predicts taken AND BTB hit
//   next_pc          next fetch PC
//   pred_ghr         history used for the current prediction
//   mispredict_count saturating misprediction count
// ---------------------------------------------------------------------------
module branch_direction_predictor #(
    parameter int INDEX_BITS = 5,
    parameter int HIST_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 en,
    input  logic [63:0]          current_pc,
    input  logic [63:0]          btb_target,
    input  logic                 upd_valid,
    input  logic [63:0]          upd_pc,
    input  logic [HIST_BITS-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic                 pred_taken,
    output logic [63:0]          next_pc,
    output logic [HIST_BITS-1:0] pred_ghr,
    output logic [31:0]          mispredict_count
);

    localparam int PHT_ENTRIES = 2 ** INDEX_BITS;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    // Pattern history table and global history
    logic [1:0]            pht_q [PHT_ENTRIES];
    logic [1:0]            pht_d [PHT_ENTRIES];
    logic [HIST_BITS-1:0]  ghr_q;
    logic [HIST_BITS-1:0]  ghr_d;

    // Lookup-stage registers, aligned with the BTB's registered output
    logic [63:0]           r_pc_q;
    logic [63:0]           r_pc_d;
    logic [1:0]            r_ctr_q;
    logic [1:0]            r_ctr_d;
    logic [HIST_BITS-1:0]  r_ghr_q;
    logic [HIST_BITS-1:0]  r_ghr_d;

    logic [31:0]           mispredict_count_q;
    logic [31:0]           mispredict_count_d;

    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] upd_ghr_ext;
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            upd_ctr;

    // PCs are word aligned, and only the index bits take part in the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{current_pc[63:INDEX_BITS+2], current_pc[1:0],
                              upd_pc[63:INDEX_BITS+2], upd_pc[1:0]};

    // Zero-extend the history to index width. This form also works when
    // HIST_BITS == INDEX_BITS, where a replication count would be zero.
    always_comb begin
        ghr_ext                       = '0;
        ghr_ext[HIST_BITS-1:0]        = ghr_q;
        upd_ghr_ext                   = '0;
        upd_ghr_ext[HIST_BITS-1:0]    = upd_ghr;
    end

    assign lookup_idx = current_pc[INDEX_BITS+1:2] ^ ghr_ext;
    assign upd_idx    = upd_pc[INDEX_BITS+1:2] ^ upd_ghr_ext;

    // Lookup reads pht_q and ghr_q. If an update to the same entry happens
    // in the same cycle, the lookup therefore sees the pre-update counter
    // and the pre-update history.
    always_comb begin
        r_pc_d  = r_pc_q;
        r_ctr_d = r_ctr_q;
        r_ghr_d = r_ghr_q;
        if (en) begin
            r_pc_d  = current_pc;
            r_ctr_d = pht_q[lookup_idx];
            r_ghr_d = ghr_q;
        end
    end

    always_comb begin
        upd_ctr = pht_q[upd_idx];
        if (upd_taken) begin
            if (upd_ctr != CTR_STRONG_T) begin
                upd_ctr = upd_ctr + 2'b01;
            end
        end else begin
            if (upd_ctr != CTR_STRONG_NT) begin
                upd_ctr = upd_ctr - 2'b01;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PHT_ENTRIES; i++) begin
            pht_d[i] = pht_q[i];
        end
        ghr_d              = ghr_q;
        mispredict_count_d = mispredict_count_q;
        if (upd_valid) begin
            pht_d[upd_idx] = upd_ctr;
            // Shift the resolved outcome in at bit 0. The loop is empty
            // for a single-bit history.
            ghr_d[0] = upd_taken;
            for (int i = 1; i < HIST_BITS; i++) begin
                ghr_d[i] = ghr_q[i-1];
            end
            if (upd_mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= CTR_WEAK_NT;
            end
            ghr_q              <= '0;
            r_pc_q             <= '0;
            r_ctr_q            <= CTR_WEAK_NT;
            r_ghr_q            <= '0;
            mispredict_count_q <= '0;
        end else begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= pht_d[i];
            end
            ghr_q              <= ghr_d;
            r_pc_q             <= r_pc_d;
            r_ctr_q            <= r_ctr_d;
            r_ghr_q            <= r_ghr_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // A zero target means a BTB miss. With no target to redirect to, fall
    // through even when the counter predicts taken. The +4 wraps mod 2**64.
    assign pred_taken       = r_ctr_q[1] & (btb_target != 64'd0);
    assign next_pc          = pred_taken ? btb_target : (r_pc_q + 64'd4);
    assign pred_ghr         = r_ghr_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_direction_predictor.sv
module tb_branch_direction_predictor;

    logic        clk;
    logic        arst_n;
    logic        en;
    logic [63:0] current_pc;
    logic [63:0] btb_target;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic [4:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;
    logic        pred_taken;
    logic [63:0] next_pc;
    logic [4:0]  pred_ghr;
    logic [31:0] mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected global history, shifted with each valid update
    logic [4:0] exp_ghr;

    branch_direction_predictor #(
        .INDEX_BITS(5),
        .HIST_BITS (5)
    ) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .en              (en),
        .current_pc      (current_pc),
        .btb_target      (btb_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_ghr         (upd_ghr),
        .upd_taken       (upd_taken),
        .upd_mispredict  (upd_mispredict),
        .pred_taken      (pred_taken),
        .next_pc         (next_pc),
        .pred_ghr        (pred_ghr),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [63:0] pc, input logic [4:0] g,
                             input logic t, input logic m);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_ghr        = g;
        upd_taken      = t;
        upd_mispredict = m;
        tick();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        exp_ghr        = {exp_ghr[3:0], t};
    endtask

    task automatic do_lookup(input logic [63:0] pc);
        en         = 1'b1;
        current_pc = pc;
        tick();
        en         = 1'b0;
    endtask

    // PC whose lookup lands on PHT entry idx under the current history
    function automatic logic [63:0] lk_pc(input logic [4:0] idx);
        lk_pc = 64'h1000 | {57'd0, idx ^ exp_ghr, 2'b00};
    endfunction

    task automatic test_reset();
        arst_n = 1'b0;
        btb_target = 64'h1234;
        #2;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got %b expected 0", pred_taken); end
        n_checks++; if (next_pc !== 64'h4) begin n_fail++; $display("FAIL reset_next_pc got %h expected 4", next_pc); end
        n_checks++; if (pred_ghr !== 5'd0) begin n_fail++; $display("FAIL reset_pred_ghr got %b expected 0", pred_ghr); end
        n_checks++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", mispredict_count); end
        tick();
        arst_n = 1'b1;
        exp_ghr = 5'd0;
        tick();
    endtask

    task automatic test_training_hit();
        do_update(64'h100, 5'd0, 1'b1, 1'b0);
        do_update(64'h100, 5'd0, 1'b1, 1'b0);
        do_lookup(64'h10C);
        btb_target = 64'h200;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL hit_pred_taken got %b expected 1", pred_taken); end
        n_checks++; if (next_pc !== 64'h200) begin n_fail++; $display("FAIL hit_next_pc got %h expected 200", next_pc); end
        n_checks++; if (pred_ghr !== 5'b00011) begin n_fail++; $display("FAIL hit_pred_ghr got %b expected 00011", pred_ghr); end
    endtask

    task automatic test_btb_miss();
        btb_target = 64'h0;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL miss_pred_taken got %b expected 0", pred_taken); end
        n_checks++; if (next_pc !== 64'h110) begin n_fail++; $display("FAIL miss_next_pc got %h expected 110", next_pc); end
    endtask

    task automatic test_saturation();
        logic [63:0] p;
        // Entry 1: 01 -> 00, held at 00 for three more NT, then +1 -> 01
        for (int i = 0; i < 4; i++) do_update(64'h104, 5'd0, 1'b0, 1'b0);
        do_update(64'h104, 5'd0, 1'b1, 1'b0);
        p = lk_pc(5'd1);
        do_lookup(p);
        btb_target = 64'h300;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_low_pred_taken got %b expected 0", pred_taken); end
        n_checks++; if (next_pc !== p + 64'd4) begin n_fail++; $display("FAIL sat_low_next_pc got %h expected %h", next_pc, p + 64'd4); end
        n_checks++; if (pred_ghr !== 5'b00001) begin n_fail++; $display("FAIL sat_low_pred_ghr got %b expected 00001", pred_ghr); end
        // One more taken -> 10
        do_update(64'h104, 5'd0, 1'b1, 1'b0);
        do_lookup(lk_pc(5'd1));
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_low_step_pred_taken got %b expected 1", pred_taken); end
        n_checks++; if (next_pc !== 64'h300) begin n_fail++; $display("FAIL sat_low_step_next_pc got %h expected 300", next_pc); end
        // Entry 0 at 11: taken holds 11, two NT -> 01
        do_update(64'h100, 5'd0, 1'b1, 1'b0);
        do_update(64'h100, 5'd0, 1'b0, 1'b0);
        do_update(64'h100, 5'd0, 1'b0, 1'b0);
        do_lookup(lk_pc(5'd0));
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_high_pred_taken got %b expected 0", pred_taken); end
        // Fall-through wraps at the top of the address space
        do_lookup(64'hFFFF_FFFF_FFFF_FFFC);
        btb_target = 64'h0;
        #1;
        n_checks++; if (next_pc !== 64'h0) begin n_fail++; $display("FAIL wrap_next_pc got %h expected 0", next_pc); end
    endtask

    task automatic test_collision();
        logic [4:0] g0;
        g0 = exp_ghr;
        en             = 1'b1;
        current_pc     = lk_pc(5'd5);
        upd_valid      = 1'b1;
        upd_pc         = 64'h14;
        upd_ghr        = 5'd0;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b0;
        tick();
        en        = 1'b0;
        upd_valid = 1'b0;
        exp_ghr   = {exp_ghr[3:0], 1'b1};
        btb_target = 64'h400;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL collide_old_pred_taken got %b expected 0", pred_taken); end
        n_checks++; if (pred_ghr !== g0) begin n_fail++; $display("FAIL collide_pred_ghr got %b expected %b", pred_ghr, g0); end
        do_lookup(lk_pc(5'd5));
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL collide_new_pred_taken got %b expected 1", pred_taken); end
    endtask

    task automatic test_stall();
        logic [63:0] p;
        logic [4:0]  gs;
        p  = lk_pc(5'd5);
        gs = exp_ghr;
        do_lookup(p);
        for (int i = 0; i < 3; i++) begin
            current_pc = 64'hDEAD_0000 + 64'(i * 4);
            do_update(64'h18, 5'd0, 1'b1, 1'b0);
            btb_target = 64'h0;
            #1;
            n_checks++; if (pred_ghr !== gs) begin n_fail++; $display("FAIL stall_pred_ghr[%0d] got %b expected %b", i, pred_ghr, gs); end
            n_checks++; if (next_pc !== p + 64'd4) begin n_fail++; $display("FAIL stall_next_pc[%0d] got %h expected %h", i, next_pc, p + 64'd4); end
            btb_target = 64'h500 + 64'(i * 16);
            #1;
            n_checks++; if (next_pc !== 64'h500 + 64'(i * 16)) begin n_fail++; $display("FAIL stall_btb_follow[%0d] got %h expected %h", i, next_pc, 64'h500 + 64'(i * 16)); end
        end
        do_lookup(lk_pc(5'd6));
        btb_target = 64'h600;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL stall_trained_pred_taken got %b expected 1", pred_taken); end
    endtask

    task automatic test_mispredict();
        n_checks++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL mis_initial got %0d expected 0", mispredict_count); end
        for (int i = 0; i < 3; i++) do_update(64'h200, 5'd0, 1'b1, 1'b1);
        upd_valid      = 1'b0;
        upd_mispredict = 1'b1;
        upd_taken      = 1'b0;
        tick();
        upd_mispredict = 1'b0;
        n_checks++; if (mispredict_count !== 32'd3) begin n_fail++; $display("FAIL mis_count got %0d expected 3", mispredict_count); end
        do_lookup(64'h1000);
        #1;
        n_checks++; if (pred_ghr !== exp_ghr) begin n_fail++; $display("FAIL mis_ghr_hold got %b expected %b", pred_ghr, exp_ghr); end
    endtask

    task automatic test_reset_mid();
        #3;
        arst_n         = 1'b0;
        btb_target     = 64'h700;
        upd_valid      = 1'b1;
        upd_pc         = 64'h18;
        upd_ghr        = 5'd0;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b1;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_pred_taken got %b expected 0", pred_taken); end
        n_checks++; if (next_pc !== 64'h4) begin n_fail++; $display("FAIL midrst_next_pc got %h expected 4", next_pc); end
        n_checks++; if (pred_ghr !== 5'd0) begin n_fail++; $display("FAIL midrst_pred_ghr got %b expected 0", pred_ghr); end
        n_checks++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL midrst_count got %0d expected 0", mispredict_count); end
        tick();
        arst_n         = 1'b1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        exp_ghr        = 5'd0;
        do_lookup(64'h18);
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_pht_cleared got %b expected 0", pred_taken); end
        n_checks++; if (pred_ghr !== 5'd0) begin n_fail++; $display("FAIL midrst_ghr_cleared got %b expected 0", pred_ghr); end
        n_checks++; if (next_pc !== 64'h1C) begin n_fail++; $display("FAIL midrst_lookup_next_pc got %h expected 1c", next_pc); end
        n_checks++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL midrst_count_after got %0d expected 0", mispredict_count); end
    endtask

    initial begin
        en             = 1'b0;
        current_pc     = 64'h0;
        btb_target     = 64'h0;
        upd_valid      = 1'b0;
        upd_pc         = 64'h0;
        upd_ghr        = 5'd0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        exp_ghr        = 5'd0;
        test_reset();
        test_training_hit();
        test_btb_miss();
        test_saturation();
        test_collision();
        test_stall();
        test_mispredict();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_direction_predictor.md
# branch_direction_predictor

Gshare direction predictor in the fetch stage, running in parallel with the branch target buffer and sitting directly downstream of it. It looks up a 2-bit saturating counter for the fetch PC and pairs it with the target the BTB returns one cycle later. From those it produces the qualified taken/not-taken decision and the next fetch PC. Execute trains it with resolved branch outcomes. A global history register and a misprediction counter are also maintained here.

## Interface
- INDEX_BITS, 5, log2 of pattern-history-table entries (PHT has 2**INDEX_BITS entries)
- HIST_BITS, 5, global history length; legal range 1..INDEX_BITS
- clk  input  1  clock, all state on rising edge
- arst_n  input  1  asynchronous active-low reset
- en  input  1  lookup enable; 0 = fetch stall
- current_pc  input  64  fetch PC presented for lookup
- btb_target  input  64  BTB predicted target; arrives one cycle after current_pc; 0 = BTB miss
- upd_valid  input  1  resolved conditional branch from execute
- upd_pc  input  64  PC of the resolved branch
- upd_ghr  input  HIST_BITS  history that was used when this branch was predicted (pred_ghr carried down the pipe)
- upd_taken  input  1  actual branch outcome
- upd_mispredict  input  1  execute detected a misprediction; qualified by upd_valid
- pred_taken  output  1  predicted taken (counter taken AND BTB hit)
- next_pc  output  64  next fetch PC
- pred_ghr  output  HIST_BITS  history used for the current prediction
- mispredict_count  output  32  saturating count of mispredictions

## Operation
- PHT: 2**INDEX_BITS 2-bit counters. 00 = strong NT, 01 = weak NT, 10 = weak T, 11 = strong T. Prediction bit = counter[1].
- Lookup index = current_pc[INDEX_BITS+1:2] XOR zero-extended ghr. PCs are word-aligned; bits [1:0] are ignored.
- Update index = upd_pc[INDEX_BITS+1:2] XOR zero-extended upd_ghr.
- Lookup stage, on a clock edge with en=1: r_pc <= current_pc; r_ctr <= pht[lookup index]; r_ghr <= ghr. With en=0 these registers hold.
- Outputs are combinational from the lookup registers and btb_target:
  - pred_taken = r_ctr[1] & (btb_target != 0)
  - next_pc = pred_taken ? btb_target : r_pc + 4, computed modulo 2**64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0)
  - pred_ghr = r_ghr
- Update, on a clock edge with upd_valid=1, independent of en:
  - Counter increments if upd_taken, else decrements, saturating at 11 and 00.
  - ghr <= {ghr[HIST_BITS-2:0], upd_taken}. Commit-time history, non-speculative. For HIST_BITS=1, ghr <= upd_taken.
  - If upd_mispredict=1, mispredict_count increments, saturating at 0xFFFF_FFFF.
- upd_valid=0: no PHT, ghr or counter change; upd_mispredict is ignored.
- Same-cycle lookup and update to the same index: the lookup captures the pre-update counter. The new value is visible from the next lookup.
- Lookup uses ghr before the same-cycle update.

## Timing
- Reset (asynchronous, immediate on arst_n=0):
  - all PHT entries = 01; ghr = 0
  - r_pc = 0; r_ctr = 01; r_ghr = 0
  - outputs: pred_taken = 0, next_pc = 0x4, pred_ghr = 0, mispredict_count = 0
- Reset asserted mid-operation discards all training and history. No update completes on the edge where reset is active.
- Latency: current_pc sampled on edge N. pred_taken/next_pc are valid after edge N, combined with the btb_target driven in that same cycle, aligned to the BTB's registered output.
- Update latency: one edge. The PHT and ghr change on the edge where upd_valid=1, and affect lookups sampled on the next edge.
- Stall (en=0): outputs still follow btb_target changes combinationally, but r_* stay frozen. Updates proceed during stall.

## Test plan
- Reset: pulse arst_n low mid-run -> pred_taken=0, next_pc=0x4, pred_ghr=0, mispredict_count=0 immediately.
- Training + hit (defaults): two updates with upd_pc=0x100, upd_ghr=0, upd_taken=1 -> entry 0 goes 01->10->11, ghr=00011. Then lookup current_pc=0x10C (index 3^3=0) with btb_target=0x200 -> pred_taken=1, next_pc=0x200, pred_ghr=00011.
- BTB miss: same trained state, btb_target=0 -> pred_taken=0, next_pc=0x110.
- Saturation: four not-taken updates to one entry, then one taken -> counter 00 then 01; a lookup of that entry gives pred_taken=0 even with btb_target nonzero. next_pc wraps: r_pc=0xFFFF_FFFF_FFFF_FFFC -> next_pc=0.
- Collision/stall: update and lookup to the same index in one cycle -> old counter used, new counter seen next lookup. With en=0 for 3 cycles, pred_ghr and r_pc hold while updates still change the PHT.
- Mispredict counter: 3 updates with upd_mispredict=1, plus one with upd_mispredict=1 and upd_valid=0 -> mispredict_count=3.
